// File: rtl/volt_monitor.sv
// Serial-ADC frame qualifier: captures volt at the end of each long-enough cs_n frame,
// block-averages 2^AVG_LOG2 samples and drives debounced, hysteretic OV/UV flags.
module volt_monitor #(
    parameter int unsigned AVG_LOG2 = 3,
    parameter int unsigned MIN_CONV = 640,
    parameter logic [15:0] OV_SET   = 16'd52000,
    parameter logic [15:0] OV_CLR   = 16'd50000,
    parameter logic [15:0] UV_SET   = 16'd8000,
    parameter logic [15:0] UV_CLR   = 16'd10000,
    parameter int unsigned DEB      = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs_n,
    input  logic [15:0] volt,
    output logic [15:0] sample,
    output logic        sample_vld,
    output logic [15:0] avg,
    output logic        avg_vld,
    output logic        ov_flag,
    output logic        uv_flag,
    output logic        short_err
);

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = DW + AVG_LOG2;
    localparam int unsigned CW    = AVG_LOG2;
    localparam int unsigned LW    = 16;
    localparam int unsigned DBW   = 4;
    localparam int unsigned NSAMP = 1 << AVG_LOG2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        LATCH = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             cs_d1_q, cs_d2_q;
    logic [LW-1:0]    len_q, len_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]    sample_q, sample_d;
    logic             sample_vld_q, sample_vld_d;
    logic [DW-1:0]    avg_q, avg_d;
    logic             avg_vld_q, avg_vld_d;
    logic [DBW-1:0]   ov_cnt_q, ov_cnt_d;
    logic [DBW-1:0]   uv_cnt_q, uv_cnt_d;
    logic             ov_q, ov_d;
    logic             uv_q, uv_d;
    logic             short_q, short_d;

    logic [AW-1:0]    sum_c;
    logic             ov_hit;
    logic             uv_hit;
    logic [DBW-1:0]   ov_next;
    logic [DBW-1:0]   uv_next;

    assign sum_c = acc_q + AW'(volt);

    // Frame FSM, accumulator and debounce next-state
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        sample_d     = sample_q;
        sample_vld_d = 1'b0;
        avg_d        = avg_q;
        avg_vld_d    = 1'b0;
        ov_cnt_d     = ov_cnt_q;
        uv_cnt_d     = uv_cnt_q;
        ov_d         = ov_q;
        uv_d         = uv_q;
        short_d      = 1'b0;
        ov_hit       = ov_q ? (avg_q < OV_CLR) : (avg_q > OV_SET);
        uv_hit       = uv_q ? (avg_q > UV_CLR) : (avg_q < UV_SET);
        ov_next      = ov_hit ? (ov_cnt_q + DBW'(1)) : '0;
        uv_next      = uv_hit ? (uv_cnt_q + DBW'(1)) : '0;

        case (state_q)
            IDLE: begin
                if (!cs_d2_q) begin
                    state_d = CONV;
                    len_d   = LW'(1);
                end
            end
            CONV: begin
                if (cs_d2_q) begin
                    if (len_q >= LW'(MIN_CONV)) begin
                        state_d = LATCH;
                    end else begin
                        short_d = 1'b1;
                        state_d = IDLE;
                    end
                end else if (len_q != '1) begin
                    len_d = len_q + LW'(1);
                end
            end
            LATCH: begin
                // cs_n activity here is ignored; IDLE restarts the next frame
                state_d      = IDLE;
                sample_d     = volt;
                sample_vld_d = 1'b1;
                if (cnt_q == CW'(NSAMP - 1)) begin
                    avg_d     = DW'(sum_c >> AVG_LOG2);
                    avg_vld_d = 1'b1;
                    acc_d     = '0;
                    cnt_d     = '0;
                end else begin
                    acc_d = sum_c;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Flags move one cycle after the average they are judged on
        if (avg_vld_q) begin
            if (ov_next == DBW'(DEB)) begin
                ov_d     = ~ov_q;
                ov_cnt_d = '0;
            end else begin
                ov_cnt_d = ov_next;
            end
            if (uv_next == DBW'(DEB)) begin
                uv_d     = ~uv_q;
                uv_cnt_d = '0;
            end else begin
                uv_cnt_d = uv_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cs_d1_q      <= 1'b1;
            cs_d2_q      <= 1'b1;
            len_q        <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            sample_q     <= '0;
            sample_vld_q <= 1'b0;
            avg_q        <= '0;
            avg_vld_q    <= 1'b0;
            ov_cnt_q     <= '0;
            uv_cnt_q     <= '0;
            ov_q         <= 1'b0;
            uv_q         <= 1'b0;
            short_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cs_d1_q      <= cs_n;
            cs_d2_q      <= cs_d1_q;
            len_q        <= len_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            sample_q     <= sample_d;
            sample_vld_q <= sample_vld_d;
            avg_q        <= avg_d;
            avg_vld_q    <= avg_vld_d;
            ov_cnt_q     <= ov_cnt_d;
            uv_cnt_q     <= uv_cnt_d;
            ov_q         <= ov_d;
            uv_q         <= uv_d;
            short_q      <= short_d;
        end
    end

    assign sample     = sample_q;
    assign sample_vld = sample_vld_q;
    assign avg        = avg_q;
    assign avg_vld    = avg_vld_q;
    assign ov_flag    = ov_q;
    assign uv_flag    = uv_q;
    assign short_err  = short_q;

endmodule
